// File: rtl/binary_div_pkg.sv
// Shared widths and the per-stage record for the pipelined restoring divider.
// BINARY_DIV_DZ_EN adds a divide-by-zero flag to the record.
package binary_div_pkg;

   localparam int WA_DEF = 6;
   localparam int WB_DEF = 3;

   // Register bank of one pipeline stage.
   // dvd is left-aligned: its MSB is the next dividend bit to consume.
   typedef struct packed {
      logic [WB_DEF-1:0] rem;
      logic [WA_DEF-1:0] quo;
      logic [WA_DEF-1:0] dvd;
      logic [WB_DEF-1:0] dvs;
      logic              vld;
`ifdef BINARY_DIV_DZ_EN
      logic              dz;
`endif
   } stage_t;

endpackage

// File: rtl/binary_div_stage.sv
// One restoring-division step (shift in a dividend bit, compare, conditional subtract)
// followed by its stage register bank; en freezes the bank.
module binary_div_stage
   import binary_div_pkg::*;
#(
   parameter int WA = WA_DEF,
   parameter int WB = WB_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  stage_t stage_i,
   output stage_t stage_o
);

   logic [WB:0] t_s;
   logic [WB:0] diff_s;
   logic        ge_s;
   logic        unused_s;
   stage_t      stage_d;
   stage_t      stage_q;

   always_comb begin
      t_s         = {stage_i.rem, stage_i.dvd[WA-1]};
      diff_s      = t_s - {1'b0, stage_i.dvs};
      ge_s        = (t_s >= {1'b0, stage_i.dvs});
      stage_d     = stage_i;
      // Since rem < dvs, T - dvs always fits back into WB bits.
      stage_d.rem = ge_s ? diff_s[WB-1:0] : t_s[WB-1:0];
      stage_d.quo = {stage_i.quo[WA-2:0], ge_s};
      stage_d.dvd = {stage_i.dvd[WA-2:0], 1'b0};
   end

   assign unused_s = diff_s[WB] ^ stage_i.quo[WA-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else if (en) begin
         stage_q <= stage_d;
      end
   end

   assign stage_o = stage_q;

endmodule

// File: rtl/binary_div_6_3_uni.sv
// Pipelined unsigned restoring divider, one quotient bit per stage, WA-cycle latency.
// Define BINARY_DIV_DZ_EN to get the dz port and forced R = 0 on divide-by-zero.
module binary_div_6_3_uni
   import binary_div_pkg::*;
#(
   parameter int WA = WA_DEF,
   parameter int WB = WB_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_valid,
   input  logic [WA-1:0] A,
   input  logic [WB-1:0] B,
   output logic          out_valid,
   output logic [WA-1:0] Q,
   output logic [WB-1:0] R
`ifdef BINARY_DIV_DZ_EN
   ,
   output logic          dz
`endif
);

   stage_t stage_in_s;
   stage_t pipe_s [0:WA];
   logic   unused_s;

   always_comb begin
      stage_in_s     = '0;
      stage_in_s.dvd = A;
      stage_in_s.dvs = B;
      stage_in_s.vld = in_valid;
`ifdef BINARY_DIV_DZ_EN
      stage_in_s.dz  = (B == '0);
`endif
   end

   assign pipe_s[0] = stage_in_s;

   genvar gi;
   generate
      for (gi = 0; gi < WA; gi++) begin : g_stage
         binary_div_stage #(
            .WA (WA),
            .WB (WB)
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .stage_i (pipe_s[gi]),
            .stage_o (pipe_s[gi+1])
         );
      end
   endgenerate

   assign out_valid = pipe_s[WA].vld;
   assign Q         = pipe_s[WA].quo;

`ifdef BINARY_DIV_DZ_EN
   // The quotient is already all ones for a zero divisor; only R needs forcing.
   assign R  = pipe_s[WA].dz ? '0 : pipe_s[WA].rem;
   assign dz = pipe_s[WA].dz;
`else
   assign R  = pipe_s[WA].rem;
`endif

   assign unused_s = ^{pipe_s[WA].dvd, pipe_s[WA].dvs};

endmodule

// File: tb/tb_binary_div_6_3_uni.sv
// Directed and exhaustive checks for binary_div_6_3_uni; one line per directed transaction.
// Honours BINARY_DIV_DZ_EN for the divide-by-zero expectations.
module tb_binary_div_6_3_uni;

   logic       clk;
   logic       rst;
   logic       en;
   logic       in_valid;
   logic [5:0] A;
   logic [2:0] B;
   logic       out_valid;
   logic [5:0] Q;
   logic [2:0] R;
`ifdef BINARY_DIV_DZ_EN
   logic       dz;
`endif

   int errors = 0;
   int checks = 0;

   binary_div_6_3_uni dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .Q         (Q),
      .R         (R)
`ifdef BINARY_DIV_DZ_EN
      ,
      .dz        (dz)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output collector used during the exhaustive sweep.
   bit          mon_on = 1'b0;
   logic        en_s;
   logic        rst_s;
   logic [8:0]  got_q [$];
   logic [8:0]  exp_q [$];

   always @(posedge clk) begin
      en_s  = en;
      rst_s = rst;
      #1;
      if (mon_on && en_s && !rst_s && out_valid)
         got_q.push_back({Q, R});
   end

   // One operation, then bubbles; measures latency in edges.
   task automatic single(input int a, input int b, input int eq, input int er, input int edz);
      int lat;
      bit found;
      @(posedge clk);
      #2;
      A = 6'(a); B = 3'(b); in_valid = 1'b1; en = 1'b1;
      lat = 0; found = 1'b0;
      for (int n = 1; n <= 12 && !found; n++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (out_valid) begin
            found = 1'b1;
            lat   = n;
         end
      end
      check($sformatf("lat_%0d_%0d", a, b), lat, 6);
      check($sformatf("q_%0d_%0d", a, b), 32'(Q), eq);
      check($sformatf("r_%0d_%0d", a, b), 32'(R), er);
`ifdef BINARY_DIV_DZ_EN
      check($sformatf("dz_%0d_%0d", a, b), 32'(dz), edz);
`endif
      $display("op %0d/%0d -> Q=%0d R=%0d latency=%0d (edz=%0d)", a, b, Q, R, lat, edz);
   endtask

   initial begin : main
      int cyc [3];
      int qv  [3];
      int rv  [3];
      int k;
      int lat;
      int seen;
      int idx;
      int a;
      int b;
      int er;
      bit found;

      rst = 1'b1; en = 1'b0; in_valid = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(out_valid), 0);
      check("reset_q", 32'(Q), 0);
      check("reset_r", 32'(R), 0);
`ifdef BINARY_DIV_DZ_EN
      check("reset_dz", 32'(dz), 0);
`endif
      @(posedge clk);
      #2 rst = 1'b0;

      // Basic cases.
      single(45, 5,  9, 0, 0);
      single(50, 3, 16, 2, 0);
      single(5,  6,  0, 5, 0);
      single(63, 1, 63, 0, 0);

      // Divide by zero: 42 = 101010b, so the natural remainder is 010b.
`ifdef BINARY_DIV_DZ_EN
      single(42, 0, 63, 0, 1);
`else
      single(42, 0, 63, 2, 0);
`endif

      // Back-to-back 63/7, 62/7, 61/7.
      @(posedge clk);
      #2;
      A = 6'd63; B = 3'd7; in_valid = 1'b1; en = 1'b1;
      k = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         if (n == 1)      A = 6'd62;
         else if (n == 2) A = 6'd61;
         else             in_valid = 1'b0;
         if (out_valid) begin
            if (k < 3) begin
               cyc[k] = n; qv[k] = 32'(Q); rv[k] = 32'(R);
            end
            k++;
         end
      end
      check("b2b_count", k, 3);
      check("b2b_cyc0", cyc[0], 6);
      check("b2b_cyc1", cyc[1], 7);
      check("b2b_cyc2", cyc[2], 8);
      check("b2b_q0", qv[0], 9);  check("b2b_r0", rv[0], 0);
      check("b2b_q1", qv[1], 8);  check("b2b_r1", rv[1], 6);
      check("b2b_q2", qv[2], 8);  check("b2b_r2", rv[2], 5);
      for (int i = 0; i < 3; i++)
         $display("b2b out %0d at edge %0d -> Q=%0d R=%0d", i, cyc[i], qv[i], rv[i]);

      // Stall: edges 4..6 disabled, so the result lands on edge 9.
      @(posedge clk);
      #2;
      A = 6'd50; B = 3'd3; in_valid = 1'b1; en = 1'b1;
      found = 1'b0; lat = 0;
      for (int n = 1; n <= 15 && !found; n++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         en = !(n >= 3 && n <= 5);
         if (out_valid) begin
            found = 1'b1;
            lat   = n;
         end
      end
      check("stall_lat", lat, 9);
      check("stall_q", 32'(Q), 16);
      check("stall_r", 32'(R), 2);
      en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("stall_hold_valid", 32'(out_valid), 1);
      check("stall_hold_q", 32'(Q), 16);
      en = 1'b1;
      $display("stall 50/3 -> Q=%0d R=%0d at edge %0d", Q, R, lat);

      // Reset mid-flight after the second of four operations has entered.
      @(posedge clk);
      #2;
      A = 6'd45; B = 3'd5; in_valid = 1'b1; en = 1'b1;
      @(posedge clk);
      #2;
      A = 6'd50; B = 3'd3;
      @(posedge clk);
      #1;
      rst = 1'b1; A = 6'd5; B = 3'd6;
      #1;
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_q", 32'(Q), 0);
      @(posedge clk);
      #2;
      A = 6'd63; B = 3'd1;
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("rst_stale", seen, 0);
      $display("reset mid-flight: stale outputs seen=%0d", seen);
      single(45, 5, 9, 0, 0);

      // Exhaustive sweep with random en and in_valid gaps.
      got_q.delete();
      exp_q.delete();
      mon_on = 1'b1;
      idx = 0;
      while (idx < 512) begin
         @(posedge clk);
         #2;
         en       = ($urandom_range(0, 3) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         a = idx >> 3;
         b = idx & 7;
         A = 6'(a);
         B = 3'(b);
         if (en && in_valid) begin
            if (b == 0) begin
`ifdef BINARY_DIV_DZ_EN
               er = 0;
`else
               er = a & 7;
`endif
               exp_q.push_back({6'd63, 3'(er)});
            end else begin
               exp_q.push_back({6'(a / b), 3'(a % b)});
            end
            idx++;
         end
      end
      repeat (12) begin
         @(posedge clk);
         #2;
         en = 1'b1; in_valid = 1'b0;
      end
      mon_on = 1'b0;
      check("exh_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("exh_%0d_%0d", i >> 3, i & 7), 32'(got_q[i]), 32'(exp_q[i]));
      $display("exhaustive: %0d results collected", got_q.size());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
